ram_access_ctrl: RTL and testbench

Command-to-RAM sequencer that sits directly upstream of the 256x32 single-port `ram` block (addr, clk, data_io, rd_en, reset_n, wr_en).
- Accepts one read or write command at a time over a valid/ready interface.
- Generates the setup-then-strobe timing the RAM requires: address and data are stable one cycle before the enable pulse, and the enable pulse lasts one cycle.
- Owns the tristate half of the shared data_io bus.
- Returns read data on a one-cycle response strobe.

---
 rtl/ram_access_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences single read/write commands onto a single-port RAM
// with one cycle of address/data setup followed by a one-cycle enable strobe.
// Owns the controller side of the shared tristate data bus and returns read
// data on a one-cycle response strobe after RD_LAT cycles of wait.
module ram_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  inout  wire  [DATA_W-1:0] ram_data_io
);

  // Counter covers the full legal RD_LAT range of 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                drive_q, drive_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  assign cmd_ready   = (state_q == IDLE);
  assign ram_addr    = addr_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_rd_en   = rd_en_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  // The bus is only ours from the accept edge of a write until its strobe ends.
  assign ram_data_io = drive_q ? wdata_q : {DATA_W{1'bz}};

  // Next-state and registered-output logic for the command sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    drive_d     = drive_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = SETUP;
          addr_d  = cmd_addr;
          we_d    = cmd_we;
          wdata_d = cmd_wdata;
          drive_d = cmd_we;
        end
      end
      SETUP: begin
        state_d = STROBE;
        wr_en_d = we_q;
        rd_en_d = !we_q;
      end
      STROBE: begin
        if (we_q) begin
          state_d = IDLE;
          drive_d = 1'b0;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ram_data_io;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and RAM-facing registers; reset aborts any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      drive_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      drive_q     <= drive_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Captured command fields; only consumed after a fresh accept, so no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl: two harnesses (RD_LAT=1 and RD_LAT=3), each
// with a behavioural RAM, directed stimulus and a queue-based scoreboard.
module tb_ram_access_ctrl;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input int lat, input string nm,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL lat%0d %s: got %h expected %h (cyc %0d)", lat, nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input int lat, input string nm);
    checks++;
    failures++;
    $display("FAIL lat%0d %s: got event expected none (cyc %0d)", lat, nm, cyc);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, ram_wr_en, ram_rd_en;
    logic [31:0] rsp_rdata;
    logic [7:0]  ram_addr;
    wire  [31:0] ram_data_io;
    logic [31:0] mem [256];
    logic [31:0] ram_dout;
    logic [3:0]  ram_dly;
    logic        done = 1'b0;
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;
    logic        drv_exp;
    int          busy_from = 1;
    int          busy_to = 0;
    exp_t        wr_q[$];
    exp_t        rd_q[$];
    exp_t        rsp_q[$];
    exp_t        e;

    ram_access_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .ram_addr   (ram_addr),
      .ram_wr_en  (ram_wr_en),
      .ram_rd_en  (ram_rd_en),
      .ram_data_io(ram_data_io)
    );

    // An undriven bus reads as all ones.
    for (genvar b = 0; b < 32; b++) begin : g_pu
      pullup (ram_data_io[b]);
    end

    // RAM model: drives read data for exactly one cycle, RD_LAT cycles after rd_en.
    assign ram_data_io = (ram_dly == 4'd1) ? ram_dout : 32'hzzzz_zzzz;

    always @(posedge clk) begin
      if (reset) begin
        ram_dly <= 4'd0;
        if (LAT == 3) mem[8'h40] <= 32'hDEADBEEF;
      end else begin
        if (ram_wr_en) mem[ram_addr] <= ram_data_io;
        if (ram_rd_en) begin
          ram_dly  <= 4'(LAT);
          ram_dout <= mem[ram_addr];
        end else if (ram_dly != 4'd0) begin
          ram_dly <= ram_dly - 4'd1;
        end
      end
    end

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
      if (cyc >= 1) begin
        drv_exp = 1'b0;
        if (wr_q.size() > 0 && (cyc == wr_q[0].c - 1 || cyc == wr_q[0].c)) drv_exp = 1'b1;
        chk(LAT, "cmd_ready", 32'(cmd_ready), 32'(!(cyc >= busy_from && cyc <= busy_to)));
        chk(LAT, "en_overlap", 32'(ram_wr_en & ram_rd_en), 32'd0);
        if (ram_dly != 4'd1) begin
          if (drv_exp) chk(LAT, "bus_wdata", ram_data_io, wr_q[0].d);
          else         chk(LAT, "bus_idle", ram_data_io, 32'hFFFF_FFFF);
        end
        if (wr_q.size() > 0 && cyc == wr_q[0].c - 1) chk(LAT, "wr_setup_addr", 32'(ram_addr), 32'(wr_q[0].a));
        if (rd_q.size() > 0 && cyc == rd_q[0].c - 1) chk(LAT, "rd_setup_addr", 32'(ram_addr), 32'(rd_q[0].a));
        if (ram_wr_en && prev_wr) unexpected(LAT, "wr_en_width");
        if (ram_rd_en && prev_rd) unexpected(LAT, "rd_en_width");
        if (ram_wr_en) begin
          if (wr_q.size() == 0) unexpected(LAT, "wr_en_extra");
          else begin
            e = wr_q.pop_front();
            chk(LAT, "wr_addr", 32'(ram_addr), 32'(e.a));
            chk(LAT, "wr_cycle", 32'(cyc), 32'(e.c));
          end
        end
        if (ram_rd_en) begin
          if (rd_q.size() == 0) unexpected(LAT, "rd_en_extra");
          else begin
            e = rd_q.pop_front();
            chk(LAT, "rd_addr", 32'(ram_addr), 32'(e.a));
            chk(LAT, "rd_cycle", 32'(cyc), 32'(e.c));
          end
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0) unexpected(LAT, "rsp_extra");
          else begin
            e = rsp_q.pop_front();
            chk(LAT, "rsp_rdata", rsp_rdata, e.d);
            chk(LAT, "rsp_cycle", 32'(cyc), 32'(e.c));
          end
        end
        prev_wr = ram_wr_en;
        prev_rd = ram_rd_en;
      end
    end

    // Issue one command; returns with t0 = accept edge, one step after it.
    task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] d,
                         input bit want_rsp, input logic [31:0] rexp, output int t0);
      int n;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = a;
      cmd_wdata = d;
      n = 0;
      while (!cmd_ready && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      if (!cmd_ready) begin
        unexpected(LAT, "accept_timeout");
        cmd_valid = 1'b0;
        t0 = -1;
      end else begin
        @(posedge clk); #1;
        t0 = cyc;
        cmd_valid = 1'b0;
        busy_from = t0;
        busy_to   = we ? t0 + 1 : t0 + 1 + LAT;
        if (we) wr_q.push_back('{a: a, d: d, c: t0 + 1});
        else    rd_q.push_back('{a: a, d: 32'd0, c: t0 + 1});
        if (!we && want_rsp) rsp_q.push_back('{a: a, d: rexp, c: t0 + 2 + LAT});
      end
    endtask

    task automatic post_reset_checks();
      chk(LAT, "rst_ram_addr", 32'(ram_addr), 32'd0);
      chk(LAT, "rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk(LAT, "rst_rd_en", 32'(ram_rd_en), 32'd0);
      chk(LAT, "rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk(LAT, "rst_rsp_rdata", rsp_rdata, 32'd0);
      chk(LAT, "rst_bus", ram_data_io, 32'hFFFF_FFFF);
    endtask

    task automatic finish_checks();
      repeat (12) @(posedge clk);
      #1;
      chk(LAT, "wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk(LAT, "rd_q_drained", 32'(rd_q.size()), 32'd0);
      chk(LAT, "rsp_q_drained", 32'(rsp_q.size()), 32'd0);
      done = 1'b1;
    endtask

    if (gi == 0) begin : g_seq
      initial begin
        int t, t1, t2;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        post_reset_checks();
        chk(LAT, "rst_cmd_ready", 32'(cmd_ready), 32'd1);
        // Write then read back the top address.
        issue(1'b1, 8'd255, 32'd99, 1'b0, 32'd0, t);
        issue(1'b0, 8'd255, 32'd0, 1'b1, 32'd99, t);
        // Back-to-back writes with cmd_valid held, then three reads.
        issue(1'b1, 8'd254, 32'd77, 1'b0, 32'd0, t1);
        issue(1'b1, 8'd253, 32'h0000_5555, 1'b0, 32'd0, t2);
        chk(LAT, "wr_wr_spacing", 32'(t2 - t1), 32'd3);
        issue(1'b0, 8'd254, 32'd0, 1'b1, 32'd77, t);
        issue(1'b0, 8'd255, 32'd0, 1'b1, 32'd99, t);
        issue(1'b0, 8'd253, 32'd0, 1'b1, 32'h0000_5555, t);
        // Reset during the WAIT cycle of a read aborts it without a response.
        issue(1'b0, 8'd255, 32'd0, 1'b0, 32'd0, t);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        busy_to = 0;
        post_reset_checks();
        @(posedge clk); #1;
        chk(LAT, "ready_after_reset", 32'(cmd_ready), 32'd1);
        issue(1'b0, 8'd254, 32'd0, 1'b1, 32'd77, t);
        // A one-cycle command pulse while a write is busy is ignored.
        issue(1'b1, 8'd10, 32'h0000_0005, 1'b0, 32'd0, t);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 8'd254;
        cmd_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        issue(1'b0, 8'd254, 32'd0, 1'b1, 32'd77, t);
        issue(1'b0, 8'd10, 32'd0, 1'b1, 32'h0000_0005, t);
        finish_checks();
      end
    end else begin : g_seq
      initial begin
        int t;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        post_reset_checks();
        // Preloaded location, three-cycle read latency.
        issue(1'b0, 8'h40, 32'd0, 1'b1, 32'hDEADBEEF, t);
        issue(1'b1, 8'h41, 32'h0BAD_F00D, 1'b0, 32'd0, t);
        issue(1'b0, 8'h41, 32'd0, 1'b1, 32'h0BAD_F00D, t);
        issue(1'b0, 8'h40, 32'd0, 1'b1, 32'hDEADBEEF, t);
        finish_checks();
      end
    end
  end

  // Wait (bounded) for both harnesses, then report.
  initial begin
    int n;
    n = 0;
    while (!(g[0].done && g[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!(g[0].done && g[1].done)) begin
      checks++;
      failures++;
      $display("FAIL sequence_timeout: got unfinished expected done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
